// File: rtl/writeback_regfile.sv
// ---------------------------------------------------------------------------
// writeback_regfile
//
// Write-back stage register file. It selects the write-back data, commits it
// to the destination register, and provides two combinational read ports.
// Register 0 is hardwired to zero. A 32-bit counter tracks committed writes.
//
// Optional feature (macro WB_BYPASS_EN):
//   When this macro is defined, a read port that addresses the register being
//   written in the current cycle returns the write-back data (write-through).
//   When the macro is undefined, the read ports return stored contents only.
//
// Parameters:
//   DATA_W        width of every register and data port
//   ADDR_W        register address width (2**ADDR_W registers)
//
// Ports:
//   clk_i         clock; all state updates on its rising edge
//   rst_i         asynchronous active-high reset
//   RegWrite_i    write-back enable from the MEM/WB stage
//   MemtoReg_i    1 selects Memdata_i, 0 selects ALUResult_i
//   ALUResult_i   ALU result
//   Memdata_i     load data
//   RDaddr_i      destination register address
//   RS1addr_i     read port 1 address
//   RS2addr_i     read port 2 address
//   RS1data_o     read port 1 data
//   RS2data_o     read port 2 data
//   WBdata_o      selected write-back data, used for forwarding
//   retire_cnt_o  count of committed register writes (wraps at 2**32)
// ---------------------------------------------------------------------------
module writeback_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic [DATA_W-1:0] ALUResult_i,
    input  logic [DATA_W-1:0] Memdata_i,
    input  logic [ADDR_W-1:0] RDaddr_i,
    input  logic [ADDR_W-1:0] RS1addr_i,
    input  logic [ADDR_W-1:0] RS2addr_i,
    output logic [DATA_W-1:0] RS1data_o,
    output logic [DATA_W-1:0] RS2data_o,
    output logic [DATA_W-1:0] WBdata_o,
    output logic [31:0]       retire_cnt_o
);

    localparam int NREG = 2 ** ADDR_W;

    // Flattened view of all register contents. Element 0 is a constant zero.
    logic [DATA_W-1:0] reg_q [NREG];
    logic [31:0]       retire_cnt_reg;
    logic              commit;

    assign WBdata_o = MemtoReg_i ? Memdata_i : ALUResult_i;

    // Writes to x0 are discarded entirely, so they never count as commits.
    // Reset is handled by the asynchronous branch of each flop.
    assign commit = RegWrite_i && (RDaddr_i != '0);

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign reg_q[gi] = '0;
            end else begin : g_store
                logic [DATA_W-1:0] q_reg;

                always_ff @(posedge clk_i or posedge rst_i) begin
                    if (rst_i) begin
                        q_reg <= '0;
                    end else if (commit && (RDaddr_i == ADDR_W'(gi))) begin
                        q_reg <= WBdata_o;
                    end
                end

                assign reg_q[gi] = q_reg;
            end
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            retire_cnt_reg <= '0;
        end else if (commit) begin
            retire_cnt_reg <= retire_cnt_reg + 32'd1;
        end
    end

    assign retire_cnt_o = retire_cnt_reg;

    // Read ports. Reset forces zero on both ports, bypass included, so that
    // the reads agree with the cleared array during reset.
    always_comb begin
        RS1data_o = reg_q[RS1addr_i];
        RS2data_o = reg_q[RS2addr_i];
`ifdef WB_BYPASS_EN
        if (commit && (RS1addr_i == RDaddr_i)) begin
            RS1data_o = WBdata_o;
        end
        if (commit && (RS2addr_i == RDaddr_i)) begin
            RS2data_o = WBdata_o;
        end
`endif
        if (rst_i) begin
            RS1data_o = '0;
            RS2data_o = '0;
        end
    end

endmodule

// File: tb/tb_writeback_regfile.sv
// ---------------------------------------------------------------------------
// tb_writeback_regfile
//
// Self-checking bench for writeback_regfile. A behavioural model, consisting
// of an array of register values and a commit counter, predicts every read
// port, the forwarding data and the retire count. Directed cases cover reset,
// the write-back mux, x0, bypass, counter wrap and back-to-back writes. These
// are followed by randomized traffic with occasional asynchronous resets.
// ---------------------------------------------------------------------------
module tb_writeback_regfile;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        RegWrite_i;
    logic        MemtoReg_i;
    logic [31:0] ALUResult_i;
    logic [31:0] Memdata_i;
    logic [4:0]  RDaddr_i;
    logic [4:0]  RS1addr_i;
    logic [4:0]  RS2addr_i;
    logic [31:0] RS1data_o;
    logic [31:0] RS2data_o;
    logic [31:0] WBdata_o;
    logic [31:0] retire_cnt_o;

    writeback_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .RegWrite_i   (RegWrite_i),
        .MemtoReg_i   (MemtoReg_i),
        .ALUResult_i  (ALUResult_i),
        .Memdata_i    (Memdata_i),
        .RDaddr_i     (RDaddr_i),
        .RS1addr_i    (RS1addr_i),
        .RS2addr_i    (RS2addr_i),
        .RS1data_o    (RS1data_o),
        .RS2data_o    (RS2data_o),
        .WBdata_o     (WBdata_o),
        .retire_cnt_o (retire_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural model of the architectural state.
    logic [31:0] model_regs [32];
    logic [31:0] model_cnt;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
        model_cnt = 32'h0;
    endtask

    function automatic logic [31:0] model_wb();
        return MemtoReg_i ? Memdata_i : ALUResult_i;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] addr);
        if (rst_i) return 32'h0;
        if (addr == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
        if (RegWrite_i && RDaddr_i != 5'd0 && RDaddr_i == addr) return model_wb();
`endif
        return model_regs[addr];
    endfunction

    task automatic drive(input logic we, input logic m2r, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [4:0] rd,
                         input logic [4:0] a1, input logic [4:0] a2);
        RegWrite_i  = we;
        MemtoReg_i  = m2r;
        ALUResult_i = alu;
        Memdata_i   = mem;
        RDaddr_i    = rd;
        RS1addr_i   = a1;
        RS2addr_i   = a2;
    endtask

    // Compare all outputs with the model for the inputs currently applied.
    task automatic check_all(input string tag);
        #1;
        check({tag, ".rs1"}, RS1data_o, model_read(RS1addr_i));
        check({tag, ".rs2"}, RS2data_o, model_read(RS2addr_i));
        check({tag, ".wb"},  WBdata_o,  model_wb());
        check({tag, ".cnt"}, retire_cnt_o, model_cnt);
    endtask

    // Perform one rising edge. The model commits exactly as the rules state.
    // Inputs change only on the falling edge.
    task automatic step();
        @(posedge clk_i);
        if (!rst_i && RegWrite_i && RDaddr_i != 5'd0) begin
            model_regs[RDaddr_i] = model_wb();
            model_cnt            = model_cnt + 32'd1;
        end
        $display("t=%0t rst=%0d we=%0d rd=%0d wb=%08h cnt=%08h",
                 $time, rst_i, RegWrite_i, RDaddr_i, model_wb(), model_cnt);
        @(negedge clk_i);
    endtask

    initial begin
        rst_i = 1'b1;
        model_reset();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5);
        @(negedge clk_i);
        @(negedge clk_i);
        check_all("reset_state");

        // Present a write in the cycle in which reset deasserts. The write
        // commits on the first edge.
        rst_i = 1'b0;
        drive(1'b1, 1'b0, 32'hDEADBEEF, 32'h0, 5'd5, 5'd5, 5'd5);
        check_all("deassert_pre");
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5);
        check_all("x5_written");

        // Assert reset asynchronously in the middle of the low phase. No edge
        // occurs before the check.
        #1;
        rst_i = 1'b1;
        model_reset();
        check_all("async_reset");
        // A write presented while reset is held does not commit.
        drive(1'b1, 1'b0, 32'h55AA55AA, 32'h0, 5'd6, 5'd6, 5'd5);
        check_all("rst_write_pre");
        step();
        check_all("rst_write_post");
        rst_i = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd6, 5'd5);
        check_all("rst_released");

        // Write-back mux selecting memory data.
        drive(1'b1, 1'b1, 32'h1, 32'h12345678, 5'd7, 5'd0, 5'd7);
        check_all("mux_pre");
        step();
        drive(1'b0, 1'b1, 32'h1, 32'h12345678, 5'd0, 5'd0, 5'd7);
        check_all("mux_post");

        // A write to x0 is discarded and is not counted.
        drive(1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd0, 5'd0);
        check_all("x0_pre");
        step();
        check_all("x0_post");

        // Bypass: x3 holds 0xA, and 0xB is presented to x3.
        drive(1'b1, 1'b0, 32'hA, 32'h0, 5'd3, 5'd3, 5'd3);
        step();
        drive(1'b1, 1'b0, 32'hB, 32'h0, 5'd3, 5'd3, 5'd3);
        check_all("bypass_pre");
`ifdef WB_BYPASS_EN
        check("bypass_rs1_val", RS1data_o, 32'hB);
`else
        check("bypass_rs1_val", RS1data_o, 32'hA);
`endif
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd3);
        check_all("bypass_post");
        check("bypass_post_val", RS2data_o, 32'hB);

        // Back-to-back writes to x9.
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b0, 32'(i), 32'h0, 5'd9, 5'd9, 5'd1);
            check_all("b2b_pre");
            step();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd9);
        check_all("b2b_post");
        check("b2b_val", RS1data_o, 32'h3);

        // Counter wrap: preload the counter with all ones, then commit once.
        force dut.retire_cnt_reg = 32'hFFFFFFFF;
        #1;
        release dut.retire_cnt_reg;
        model_cnt = 32'hFFFFFFFF;
        drive(1'b1, 1'b0, 32'h77, 32'h0, 5'd1, 5'd1, 5'd2);
        check_all("wrap_pre");
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd2);
        check_all("wrap_post");
        check("wrap_zero", retire_cnt_o, 32'h0);

        // Randomized traffic. A narrow address range is used so that
        // collisions and x0 writes occur often.
        for (int n = 0; n < 300; n++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom),
                  32'($urandom), 32'($urandom),
                  5'(($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            if ($urandom_range(0, 39) == 0) begin
                rst_i = 1'b1;
                model_reset();
            end
            check_all("rand_pre");
            step();
            if (rst_i) begin
                rst_i = 1'b0;
            end
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd2);
        check_all("rand_end");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
